// File: rtl/audio_capture.sv
// rtl/audio_capture.sv - 1-bit audio sampler packing MSB-first 16-bit words into a read FIFO
// Optional feature macro: AUDIO_CAPTURE_MAJORITY_EN (3-tap majority glitch filter on samples)
module audio_capture #(
  parameter logic [15:0] SAMPLE_DIV = 16'd2500,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic                  Master_Clock_In,
  input  logic                  Master_Reset_N_In,
  input  logic                  Signal_In,
  input  logic                  Capture_En_In,
  input  logic                  Rd_En_In,
  output logic [15:0]           Data_Out,
  output logic                  Data_Valid_Out,
  output logic                  Empty_Out,
  output logic                  Full_Out,
  output logic                  Overflow_Out,
  output logic [DEPTH_LOG2:0]   Word_Count_Out
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;
  state_t state, state_next;

  logic        sync1, sync2, sample;
  logic        start, tick, wr_en, rd_ok, wr_ok;
  logic [15:0] div;
  logic [3:0]  bit_cnt;
  logic [15:0] shift, wr_data;
  logic [15:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_next;

  always_ff @(posedge Master_Clock_In or negedge Master_Reset_N_In) begin
    if (!Master_Reset_N_In) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= Signal_In;
      sync2 <= sync1;
    end
  end

`ifdef AUDIO_CAPTURE_MAJORITY_EN
  logic hist1, hist2;
  always_ff @(posedge Master_Clock_In or negedge Master_Reset_N_In) begin
    if (!Master_Reset_N_In) begin
      hist1 <= 1'b0;
      hist2 <= 1'b0;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
    end
  end
  assign sample = (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
`else
  assign sample = sync2;
`endif

  always_ff @(posedge Master_Clock_In or negedge Master_Reset_N_In) begin
    if (!Master_Reset_N_In) state <= IDLE;
    else                    state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (Capture_En_In) begin
          state_next = CAPTURE;
          start      = 1'b1;
        end
      end
      CAPTURE: if (!Capture_En_In) state_next = FLUSH;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign tick = (state == CAPTURE) && (div == SAMPLE_DIV - 16'd1);

  always_ff @(posedge Master_Clock_In or negedge Master_Reset_N_In) begin
    if (!Master_Reset_N_In) begin
      div     <= 16'd0;
      bit_cnt <= 4'd0;
      shift   <= 16'd0;
    end else if (start) begin
      div     <= 16'd0;
      bit_cnt <= 4'd0;
      shift   <= 16'd0;
    end else if (state == CAPTURE) begin
      div <= tick ? 16'd0 : div + 16'd1;
      if (tick) begin
        shift   <= {shift[14:0], sample};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      div <= 16'd0;
    end
  end

  // A partial word at flush holds bit_cnt samples in the low bits; left-align them.
  assign wr_en   = (tick && bit_cnt == 4'd15) || (state == FLUSH && bit_cnt != 4'd0);
  assign wr_data = tick ? {shift[14:0], sample} : (shift << (5'd16 - {1'b0, bit_cnt}));

  assign rd_ok = Rd_En_In && (count != '0);
  assign wr_ok = wr_en && ((count != FULL_CNT) || rd_ok);

  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok)      count_next = count + CNT_ONE;
    else if (rd_ok && !wr_ok) count_next = count - CNT_ONE;
  end

  always_ff @(posedge Master_Clock_In) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge Master_Clock_In or negedge Master_Reset_N_In) begin
    if (!Master_Reset_N_In) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      Data_Out       <= 16'd0;
      Data_Valid_Out <= 1'b0;
      Empty_Out      <= 1'b1;
      Full_Out       <= 1'b0;
      Overflow_Out   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        Data_Out <= mem[rd_ptr];
      end
      Data_Valid_Out <= rd_ok;
      count          <= count_next;
      Empty_Out      <= (count_next == '0);
      Full_Out       <= (count_next == FULL_CNT);
      if (start)               Overflow_Out <= 1'b0;
      else if (wr_en && !wr_ok) Overflow_Out <= 1'b1;
    end
  end

  assign Word_Count_Out = count;
endmodule

// File: tb/tb_audio_capture.sv
// tb/tb_audio_capture.sv - randomized self-checking bench for audio_capture against a sample-history model
module tb_audio_capture;
  localparam logic [15:0] DIV = 16'd4;
  localparam int DL2 = 4;
  localparam int HSZ = 8192;

  logic clk = 1'b0, rst_n = 1'b0, sig = 1'b0, en = 1'b0, rd = 1'b0;
  logic [15:0] dout;
  logic dvalid, empty, full, ovf;
  logic [DL2:0] wcnt;

  int comps = 0, fails = 0;
  int ecnt = 0;
  logic hist [HSZ];
  logic [15:0] exp_q [$];
  logic exp_ovf = 1'b0;
  logic [15:0] last_read = 16'h0;

  audio_capture #(.SAMPLE_DIV(DIV), .DEPTH_LOG2(DL2)) dut (
    .Master_Clock_In(clk), .Master_Reset_N_In(rst_n), .Signal_In(sig),
    .Capture_En_In(en), .Rd_En_In(rd), .Data_Out(dout), .Data_Valid_Out(dvalid),
    .Empty_Out(empty), .Full_Out(full), .Overflow_Out(ovf), .Word_Count_Out(wcnt)
  );

  always #20 clk = ~clk;

  // Record the input level seen at every rising edge; samples are derived from this history.
  always @(posedge clk) begin
    hist[ecnt % HSZ] <= sig;
    ecnt <= ecnt + 1;
  end

  function automatic logic model_sample(input int t);
`ifdef AUDIO_CAPTURE_MAJORITY_EN
    int ones;
    ones = int'(hist[(t-2) % HSZ]) + int'(hist[(t-3) % HSZ]) + int'(hist[(t-4) % HSZ]);
    return ones >= 2;
`else
    return hist[(t-2) % HSZ];
`endif
  endfunction

  task automatic model_write(input logic [15:0] w, input bit with_read, output logic [15:0] popped);
    popped = 16'h0;
    if (with_read && exp_q.size() > 0) popped = exp_q.pop_front();
    if (exp_q.size() < 16) exp_q.push_back(w);
    else exp_ovf = 1'b1;
  endtask

  task automatic model_capture(input int e0, input int nticks, input int rd_word, output logic [15:0] popped);
    logic [15:0] w, p;
    int n;
    w = 16'h0; n = 0; popped = 16'h0; exp_ovf = 1'b0;
    for (int j = 1; j <= nticks; j++) begin
      w = {w[14:0], model_sample(e0 + 4*j)};
      n++;
      if (n == 16) begin
        model_write(w, (j/16) == rd_word, p);
        if ((j/16) == rd_word) popped = p;
        w = 16'h0; n = 0;
      end
    end
    if (n > 0) model_write(w << (16 - n), 1'b0, p);
  endtask

  // mode: 0 random bits, 1 all ones, 2 alternating from 1, 3 all ones with a glitch before tick 1
  task automatic capture(input int nticks, input int mode, input int rd_word, input bit chk_empty,
                         output int e0, output logic [15:0] rd_obs);
    logic b;
    rd_obs = 16'h0;
    @(negedge clk);
    en = 1'b1;
    e0 = ecnt;
    sig = (mode == 0) ? 1'($urandom % 2) : 1'b1;
    @(negedge clk);
    for (int j = 1; j <= nticks; j++) begin
      case (mode)
        0:       b = 1'($urandom % 2);
        2:       b = (j % 2) == 1;
        default: b = 1'b1;
      endcase
      for (int k = 0; k < 4; k++) begin
        sig = (mode == 3 && j == 1 && k == 1) ? 1'b0 : b;
        if (rd_word != 0 && j == 16*rd_word && k == 3) rd = 1'b1;
        if (chk_empty && j == 16 && k == 3) begin
          comps++;
          if (empty !== 1'b1) begin fails++; $display("FAIL empty_before_write: got %b expected 1", empty); end
        end
        @(negedge clk);
        rd = 1'b0;
      end
    end
    if (chk_empty) begin
      comps++;
      if (empty !== 1'b0) begin fails++; $display("FAIL empty_after_write: got %b expected 0", empty); end
    end
    if (rd_word != 0) rd_obs = dout;
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_read(output logic [15:0] d, output logic v);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = dout;
    v = dvalid;
  endtask

  task automatic drain(input string name);
    logic [15:0] d, e;
    logic v;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      do_read(d, v);
      comps++;
      if (d !== e || v !== 1'b1) begin
        fails++;
        $display("FAIL %s_read: got %h valid %b expected %h valid 1", name, d, v, e);
      end
      last_read = e;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    comps += 6;
    if (dout !== 16'h0)  begin fails++; $display("FAIL reset_data: got %h expected 0000", dout); end
    if (dvalid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", dvalid); end
    if (empty !== 1'b1)  begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
    if (full !== 1'b0)   begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
    if (ovf !== 1'b0)    begin fails++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    if (wcnt !== 5'd0)   begin fails++; $display("FAIL reset_count: got %0d expected 0", wcnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_all_ones();
    int e0;
    logic [15:0] r, d;
    logic v;
    sig = 1'b1;
    repeat (4) @(negedge clk);
    capture(16, 1, 0, 1'b1, e0, r);
    model_capture(e0, 16, 0, r);
    comps++;
    if (wcnt !== 5'd1) begin fails++; $display("FAIL ones_count: got %0d expected 1", wcnt); end
    do_read(d, v);
    void'(exp_q.pop_front());
    comps++;
    if (d !== 16'hFFFF || v !== 1'b1) begin fails++; $display("FAIL ones_word: got %h valid %b expected ffff valid 1", d, v); end
    @(negedge clk);
    comps++;
    if (dvalid !== 1'b0) begin fails++; $display("FAIL ones_pulse_width: got %b expected 0", dvalid); end
    last_read = 16'hFFFF;
  endtask

  task automatic test_alternate();
    int e0;
    logic [15:0] r, d;
    logic v;
    capture(16, 2, 0, 1'b0, e0, r);
    model_capture(e0, 16, 0, r);
    do_read(d, v);
    void'(exp_q.pop_front());
    comps++;
    if (d !== 16'hAAAA || v !== 1'b1) begin fails++; $display("FAIL alt_word: got %h valid %b expected aaaa valid 1", d, v); end
    last_read = 16'hAAAA;
  endtask

  task automatic test_flush();
    int e0;
    logic [15:0] r, d;
    logic v;
    capture(5, 1, 0, 1'b0, e0, r);
    model_capture(e0, 5, 0, r);
    comps++;
    if (wcnt !== 5'd1) begin fails++; $display("FAIL flush_count: got %0d expected 1", wcnt); end
    do_read(d, v);
    void'(exp_q.pop_front());
    comps++;
    if (d !== 16'hF800) begin fails++; $display("FAIL flush_word: got %h expected f800", d); end
    last_read = 16'hF800;
  endtask

  task automatic test_random();
    int e0, n;
    logic [15:0] r;
    for (int it = 0; it < 3; it++) begin
      n = 16*int'($urandom_range(0, 3)) + int'($urandom_range(1, 15));
      capture(n, 0, 0, 1'b0, e0, r);
      model_capture(e0, n, 0, r);
      comps++;
      if (wcnt !== 5'(exp_q.size())) begin fails++; $display("FAIL random_count: got %0d expected %0d", wcnt, exp_q.size()); end
      drain("random");
    end
  endtask

  task automatic test_overflow();
    int e0;
    logic [15:0] r, d;
    logic v;
    capture(17*16, 0, 0, 1'b0, e0, r);
    model_capture(e0, 17*16, 0, r);
    comps += 3;
    if (full !== 1'b1)    begin fails++; $display("FAIL ovf_full: got %b expected 1", full); end
    if (ovf !== exp_ovf)  begin fails++; $display("FAIL ovf_flag: got %b expected %b", ovf, exp_ovf); end
    if (wcnt !== 5'd16)   begin fails++; $display("FAIL ovf_count: got %0d expected 16", wcnt); end
    drain("ovf");
    comps++;
    if (empty !== 1'b1) begin fails++; $display("FAIL ovf_empty_after_drain: got %b expected 1", empty); end
    do_read(d, v);
    comps += 2;
    if (v !== 1'b0)        begin fails++; $display("FAIL empty_read_valid: got %b expected 0", v); end
    if (d !== last_read)   begin fails++; $display("FAIL empty_read_hold: got %h expected %h", d, last_read); end
  endtask

  task automatic test_rw_full();
    int e0;
    logic [15:0] obs, pop;
    capture(17*16, 0, 17, 1'b0, e0, obs);
    model_capture(e0, 17*16, 17, pop);
    comps += 4;
    if (wcnt !== 5'd16)  begin fails++; $display("FAIL rwfull_count: got %0d expected 16", wcnt); end
    if (ovf !== exp_ovf) begin fails++; $display("FAIL rwfull_ovf: got %b expected %b", ovf, exp_ovf); end
    if (full !== 1'b1)   begin fails++; $display("FAIL rwfull_full: got %b expected 1", full); end
    if (obs !== pop)     begin fails++; $display("FAIL rwfull_read: got %h expected %h", obs, pop); end
    drain("rwfull");
  endtask

  task automatic test_glitch();
    int e0;
    logic [15:0] r;
    capture(16, 3, 0, 1'b0, e0, r);
    model_capture(e0, 16, 0, r);
    drain("glitch");
  endtask

  task automatic test_mid_reset();
    logic [15:0] d;
    logic v;
    @(negedge clk);
    en = 1'b1;
    repeat (3*64 + 24) begin
      sig = 1'($urandom % 2);
      @(negedge clk);
    end
    comps++;
    if (wcnt !== 5'd3) begin fails++; $display("FAIL midrst_count_before: got %0d expected 3", wcnt); end
    #5 rst_n = 1'b0;
    #1;
    comps += 6;
    if (dout !== 16'h0)  begin fails++; $display("FAIL midrst_data: got %h expected 0000", dout); end
    if (dvalid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", dvalid); end
    if (empty !== 1'b1)  begin fails++; $display("FAIL midrst_empty: got %b expected 1", empty); end
    if (full !== 1'b0)   begin fails++; $display("FAIL midrst_full: got %b expected 0", full); end
    if (ovf !== 1'b0)    begin fails++; $display("FAIL midrst_ovf: got %b expected 0", ovf); end
    if (wcnt !== 5'd0)   begin fails++; $display("FAIL midrst_count: got %0d expected 0", wcnt); end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_read(d, v);
    comps++;
    if (v !== 1'b0) begin fails++; $display("FAIL midrst_read_after: got valid %b expected 0", v); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_alternate();
    test_flush();
    test_random();
    test_overflow();
    test_rw_full();
    test_glitch();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end
endmodule

// File: doc/audio_capture.md
# audio_capture

Capture-side counterpart of the 1-bit audio playback path. Samples a single-bit audio input at a fixed sampling rate derived from the 25 MHz master clock and packs the samples MSB-first into 16-bit words. Buffers the words in an internal FIFO for a downstream reader (storage or transfer logic) that drains them with a read-enable handshake. Sits between the external 1-bit audio source and the system's sample storage.

## Interface
- SAMPLE_DIV, 16'd2500, master-clock cycles per sample (25 MHz / sampling frequency); legal range 4..65535
- DEPTH_LOG2, 4, log2 of FIFO depth in 16-bit words (default 16 words)
- Master_Clock_In  input  1  master clock, 25 MHz
- Master_Reset_N_In  input  1  asynchronous, active-low reset
- Signal_In  input  1  raw 1-bit audio input, asynchronous to the clock
- Capture_En_In  input  1  level; high = capture, low = stop (partial word flushed)
- Rd_En_In  input  1  read request; pops one word when FIFO not empty
- Data_Out  output  16  last word read; first sample in bit 15
- Data_Valid_Out  output  1  one-cycle pulse, Data_Out updated this cycle
- Empty_Out  output  1  FIFO empty
- Full_Out  output  1  FIFO holds 2^DEPTH_LOG2 words
- Overflow_Out  output  1  sticky; a completed word was dropped on full
- Word_Count_Out  output  DEPTH_LOG2+1  words currently in FIFO

## Operation
- Reset values: Data_Out=0, Data_Valid_Out=0, Empty_Out=1, Full_Out=0, Overflow_Out=0, Word_Count_Out=0. State=IDLE. Divider, bit counter, shift register, and FIFO pointers are cleared. Reset asserted mid-capture discards all buffered and partial data.
- Signal_In passes through a 2-flop synchronizer before any use.
- States: IDLE, CAPTURE, FLUSH.
  - IDLE -> CAPTURE when Capture_En_In=1. Transition clears divider, bit counter, shift register, and Overflow_Out.
  - CAPTURE -> FLUSH when Capture_En_In=0.
  - FLUSH -> IDLE after exactly one cycle.
- Divider counts 0..SAMPLE_DIV-1 only in CAPTURE and wraps to 0. Sample tick occurs on the cycle the count equals SAMPLE_DIV-1. Divider is held at 0 in IDLE/FLUSH.
- On each tick: shift = {shift[14:0], sample}; bit counter increments mod 16.
- Tick with bit counter=15: word {shift[14:0], sample} is written to FIFO on that edge; bit counter wraps to 0.
- FLUSH with bit counter=n (1..15): writes the n samples left-aligned with zeros in the low 16-n bits. With n=0, nothing is written.
- FIFO write when full and no simultaneous read: word dropped, Overflow_Out set (stays set until reset or the next IDLE->CAPTURE).
- Write and read in the same cycle: both take effect, including when full (count unchanged, no overflow) and when empty (read ignored, count becomes 1).
- Rd_En_In while empty is ignored: no pulse, Data_Out holds.
- Capture_En_In reasserted during FLUSH is honoured from IDLE the following cycle.

## Timing
- Input-to-sample latency: the sample taken at a tick is Signal_In as registered 2 cycles earlier (synchronizer depth).
- First tick occurs SAMPLE_DIV cycles after the cycle that enters CAPTURE.
- A word completes at tick 16k. Word_Count_Out, Empty_Out, and Full_Out update the cycle after the write edge.
- Read latency: Rd_En_In high at edge t -> Data_Out valid and Data_Valid_Out=1 in the cycle after t. Count decrements in the same cycle.
- Flags are registered; no combinational path from any input to any output.

## Configuration
- AUDIO_CAPTURE_MAJORITY_EN defined: each sample is the majority of the synchronized input on the tick cycle and the two preceding cycles, which suppresses single-cycle glitches. Adds no latency beyond the synchronizer.
- Not defined: each sample is the synchronized input on the tick cycle only.

## Test plan
- SAMPLE_DIV=4, Signal_In=1 held, Capture_En_In=1 for 64+ cycles -> first word 16'hFFFF. Empty_Out falls 1 cycle after the 16th tick. Rd_En_In -> Data_Out=16'hFFFF with a one-cycle Data_Valid_Out pulse.
- SAMPLE_DIV=4, Signal_In toggled each sample period starting at 1 -> word 16'hAAAA.
- Signal_In=1, Capture_En_In dropped after 5 ticks -> FLUSH writes 16'hF800, Word_Count_Out=1, state returns to IDLE.
- DEPTH_LOG2=4, capture 17 words with no reads -> Full_Out=1 after word 16, 17th word dropped, Overflow_Out=1. Reads return words 1..16 in order, then Empty_Out=1.
- Rd_En_In while empty -> no Data_Valid_Out, Data_Out unchanged. Simultaneous read and write at full -> count stays 16, Overflow_Out stays 0.
- Master_Reset_N_In pulsed low mid-word with 3 words buffered -> all outputs at reset values immediately (asynchronous), state IDLE. With AUDIO_CAPTURE_MAJORITY_EN, a one-cycle 0 glitch in held 1 input -> sample remains 1.
